// File: rtl/prbs_ddr_checker_if.sv
// Bit-pair stream into the PRBS-7 DDR checker plus its status outputs.
// FIRST_ERR_POS/FIRST_ERR_VLD exist only when PRBS_CHK_FIRST_ERR_EN is defined.
interface prbs_ddr_checker_if #(
  parameter int CNT_WIDTH = 16
);
  logic [1:0]           D;
  logic                 VALID;
  logic                 ERR_CLR;
  logic                 LOCKED;
  logic                 ERR;
  logic [CNT_WIDTH-1:0] ERR_CNT;
`ifdef PRBS_CHK_FIRST_ERR_EN
  logic [CNT_WIDTH-1:0] FIRST_ERR_POS;
  logic                 FIRST_ERR_VLD;

  modport master (output D, VALID, ERR_CLR,
                  input  LOCKED, ERR, ERR_CNT, FIRST_ERR_POS, FIRST_ERR_VLD);
  modport slave  (input  D, VALID, ERR_CLR,
                  output LOCKED, ERR, ERR_CNT, FIRST_ERR_POS, FIRST_ERR_VLD);
`else
  modport master (output D, VALID, ERR_CLR,
                  input  LOCKED, ERR, ERR_CNT);
  modport slave  (input  D, VALID, ERR_CLR,
                  output LOCKED, ERR, ERR_CNT);
`endif
endinterface

// File: rtl/prbs_ddr_checker.sv
// Self-synchronising PRBS-7 (x^7+x^6+1) checker for a 2-bit/cycle DDR stream; 1-cycle registered outputs.
// Optional first-error position capture is built when PRBS_CHK_FIRST_ERR_EN is defined.
module prbs_ddr_checker #(
  parameter int LOCK_CNT  = 16,
  parameter int LOSS_CNT  = 4,
  parameter int CNT_WIDTH = 16,
  parameter bit SWAP      = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  prbs_ddr_checker_if.slave bus
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

  state_t               state_q;
  logic [6:0]           seed_q;
  logic [6:0]           model_q;
  logic [1:0]           fill_q;
  logic [MW-1:0]        match_cnt_q;
  logic [BW-1:0]        bad_cnt_q;
  logic                 locked_q;
  logic                 err_q;
  logic [CNT_WIDTH-1:0] err_cnt_q;

  logic [1:0]           d_pair;
  logic [1:0]           pred;
  logic [1:0]           miss;
  logic [1:0]           errs;
  logic [6:0]           seed_d;
  logic [6:0]           model_adv;
  logic                 lock_go;
  logic                 err_d;
  logic [CNT_WIDTH-1:0] cnt_base;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic [CNT_WIDTH-1:0] err_cnt_d;

  // Bit 0 of the model/seed is the most recent bit; pred[0] is the earlier of the pair.
  assign d_pair    = SWAP ? {bus.D[0], bus.D[1]} : bus.D;
  assign pred      = {model_q[5] ^ model_q[4], model_q[6] ^ model_q[5]};
  assign miss      = pred ^ d_pair;
  assign model_adv = {model_q[4:0], pred[0], pred[1]};
  assign seed_d    = {seed_q[4:0], d_pair[0], d_pair[1]};
  assign errs      = (bus.VALID && state_q == S_LOCKED) ?
                     ({1'b0, miss[0]} + {1'b0, miss[1]}) : 2'd0;
  assign lock_go   = bus.VALID && (state_q == S_VERIFY) && (miss == 2'b00) &&
                     (match_cnt_q == MW'(LOCK_CNT - 1));

  // Clear applies before this cycle's errors are accumulated.
  always_comb begin
    cnt_base  = bus.ERR_CLR ? '0 : err_cnt_q;
    cnt_sum   = {1'b0, cnt_base} + {{(CNT_WIDTH-1){1'b0}}, errs};
    err_cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    err_d     = (err_q & ~bus.ERR_CLR) | (errs != 2'd0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_HUNT;
      seed_q      <= '0;
      model_q     <= '0;
      fill_q      <= '0;
      match_cnt_q <= '0;
      bad_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      if (bus.VALID) begin
        unique case (state_q)
          S_HUNT: begin
            seed_q <= seed_d;
            if (fill_q == 2'd3) begin
              fill_q  <= '0;
              model_q <= seed_d;
              if (seed_d != 7'd0) state_q <= S_VERIFY;
            end else begin
              fill_q <= fill_q + 2'd1;
            end
          end
          S_VERIFY: begin
            model_q <= model_adv;
            if (miss != 2'b00) begin
              state_q     <= S_HUNT;
              match_cnt_q <= '0;
            end else if (lock_go) begin
              state_q     <= S_LOCKED;
              locked_q    <= 1'b1;
              match_cnt_q <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + 1'b1;
            end
          end
          S_LOCKED: begin
            model_q <= model_adv;
            if (miss == 2'b00) begin
              bad_cnt_q <= '0;
            end else if (bad_cnt_q == BW'(LOSS_CNT - 1)) begin
              state_q   <= S_HUNT;
              locked_q  <= 1'b0;
              bad_cnt_q <= '0;
            end else begin
              bad_cnt_q <= bad_cnt_q + 1'b1;
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

  assign bus.LOCKED  = locked_q;
  assign bus.ERR     = err_q;
  assign bus.ERR_CNT = err_cnt_q;

`ifdef PRBS_CHK_FIRST_ERR_EN
  logic [CNT_WIDTH-1:0] vcnt_q;
  logic [CNT_WIDTH-1:0] first_pos_q;
  logic                 first_vld_q;
  logic                 first_base;

  assign first_base = first_vld_q & ~bus.ERR_CLR;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vcnt_q      <= '0;
      first_pos_q <= '0;
      first_vld_q <= 1'b0;
    end else begin
      if (lock_go) begin
        vcnt_q <= '0;
      end else if (bus.VALID && vcnt_q != '1) begin
        vcnt_q <= vcnt_q + 1'b1;
      end
      if (errs != 2'd0 && !first_base) begin
        first_pos_q <= vcnt_q;
        first_vld_q <= 1'b1;
      end else if (bus.ERR_CLR) begin
        first_pos_q <= '0;
        first_vld_q <= 1'b0;
      end
    end
  end

  assign bus.FIRST_ERR_POS = first_pos_q;
  assign bus.FIRST_ERR_VLD = first_vld_q;
`endif
endmodule

// File: tb/tb_prbs_ddr_checker.sv
// Directed + randomized bench for prbs_ddr_checker (CNT_WIDTH 16 and 4 side by side) against a bit-level model.
module tb_prbs_ddr_checker;
  localparam int LOCK = 16;
  localparam int LOSS = 4;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCK = 2;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  prbs_ddr_checker_if #(.CNT_WIDTH(16)) if16 ();
  prbs_ddr_checker_if #(.CNT_WIDTH(4))  if4  ();

  prbs_ddr_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_WIDTH(16), .SWAP(1'b0))
    dut16 (.CLK(clk), .RST_N(rst_n), .bus(if16.slave));
  prbs_ddr_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_WIDTH(4), .SWAP(1'b0))
    dut4  (.CLK(clk), .RST_N(rst_n), .bus(if4.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: bit history queues, plain integer counters.
  int m_mode, m_match, m_bad, m_cnt16, m_cnt4;
  bit m_err;
  bit hunt_q[$];
  bit hist[$];
  bit src[$];

  task automatic model_reset();
    m_mode = M_HUNT; m_match = 0; m_bad = 0; m_cnt16 = 0; m_cnt4 = 0; m_err = 0;
    hunt_q.delete();
    hist.delete();
  endtask

  function automatic bit hist_pred();
    return hist[hist.size()-7] ^ hist[hist.size()-6];
  endfunction

  task automatic model_step(input bit v, input bit clr, input bit [1:0] d);
    int e = 0;
    int ones;
    bit p;
    bit mism;
    if (clr) begin m_err = 0; m_cnt16 = 0; m_cnt4 = 0; end
    if (v) begin
      if (m_mode == M_HUNT) begin
        hunt_q.push_back(d[0]);
        hunt_q.push_back(d[1]);
        if (hunt_q.size() == 8) begin
          hist.delete();
          ones = 0;
          for (int i = 1; i < 8; i++) begin
            hist.push_back(hunt_q[i]);
            ones += int'(hunt_q[i]);
          end
          hunt_q.delete();
          if (ones > 0) begin m_mode = M_VERIFY; m_match = 0; end
        end
      end else if (m_mode == M_VERIFY) begin
        mism = 0;
        for (int k = 0; k < 2; k++) begin
          p = hist_pred();
          if (p != d[k]) mism = 1;
          hist.push_back(p);
        end
        if (mism) begin
          m_mode = M_HUNT; m_match = 0;
        end else begin
          m_match++;
          if (m_match == LOCK) begin m_mode = M_LOCK; m_bad = 0; end
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          p = hist_pred();
          if (p != d[k]) e++;
          hist.push_back(p);
        end
        if (e > 0) begin
          m_bad++;
          if (m_bad == LOSS) begin m_mode = M_HUNT; m_bad = 0; end
        end else begin
          m_bad = 0;
        end
      end
      while (hist.size() > 14) void'(hist.pop_front());
    end
    if (e > 0) m_err = 1;
    m_cnt16 = (m_cnt16 + e > 65535) ? 65535 : m_cnt16 + e;
    m_cnt4  = (m_cnt4 + e > 15) ? 15 : m_cnt4 + e;
  endtask

  task automatic next_pair(output bit [1:0] p);
    bit b0, b1;
    b0 = src[src.size()-7] ^ src[src.size()-6];
    src.push_back(b0);
    b1 = src[src.size()-7] ^ src[src.size()-6];
    src.push_back(b1);
    while (src.size() > 14) void'(src.pop_front());
    p = {b1, b0};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "/locked16"}, 32'(if16.LOCKED), 32'(m_mode == M_LOCK));
    chk({tag, "/err16"},    32'(if16.ERR),    32'(m_err));
    chk({tag, "/cnt16"},    32'(if16.ERR_CNT), 32'(m_cnt16));
    chk({tag, "/locked4"},  32'(if4.LOCKED),  32'(m_mode == M_LOCK));
    chk({tag, "/err4"},     32'(if4.ERR),     32'(m_err));
    chk({tag, "/cnt4"},     32'(if4.ERR_CNT), 32'(m_cnt4));
  endtask

  task automatic drive(input bit v, input bit clr, input bit [1:0] d);
    if16.VALID = v; if16.ERR_CLR = clr; if16.D = d;
    if4.VALID  = v; if4.ERR_CLR  = clr; if4.D  = d;
  endtask

  task automatic cyc(input bit v, input bit clr, input bit [1:0] d, input string tag);
    drive(v, clr, d);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(v, clr, d);
    #1;
    compare_all(tag);
  endtask

  task automatic clean(input int n, input bit clr);
    bit [1:0] p;
    for (int i = 0; i < n; i++) begin
      next_pair(p);
      cyc(1'b1, clr, p, "clean");
    end
  endtask

  task automatic inject(input bit [1:0] mask, input bit clr, input string tag);
    bit [1:0] p;
    next_pair(p);
    cyc(1'b1, clr, p ^ mask, tag);
  endtask

  // Lock must appear exactly after the 20th valid cycle of a clean stream.
  task automatic lock20(input string tag);
    bit [1:0] p;
    for (int i = 0; i < 4 + LOCK; i++) begin
      next_pair(p);
      cyc(1'b1, 1'b0, p, tag);
      if (i == 4 + LOCK - 2) chk({tag, "/early"}, 32'(if16.LOCKED), 32'd0);
    end
    chk({tag, "/locked"}, 32'(if16.LOCKED), 32'd1);
  endtask

  initial begin
    bit [1:0] p;
    int       gap;
    int       seed;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00);
    model_reset();
    seed = int'($urandom_range(1, 127));
    for (int i = 0; i < 7; i++) src.push_back(seed[i]);

    repeat (3) cyc(1'b0, 1'b0, 2'b00, "reset");
    rst_n = 1'b1;

    // All-zero input: every seed is rejected, 50 complete fills.
    for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0, 2'b00, "zeros");
    chk("zeros/never_locked", 32'(if16.LOCKED), 32'd0);

    lock20("first_lock");
    clean(1000, 1'b0);
    chk("clean/err", 32'(if16.ERR), 32'd0);
    chk("clean/cnt", 32'(if16.ERR_CNT), 32'd0);

    inject(2'b10, 1'b0, "flip_d1");
    chk("flip_d1/err", 32'(if16.ERR), 32'd1);
    chk("flip_d1/cnt", 32'(if16.ERR_CNT), 32'd1);
    chk("flip_d1/locked", 32'(if16.LOCKED), 32'd1);
    clean(1, 1'b0);
    inject(2'b11, 1'b0, "flip_both");
    chk("flip_both/cnt", 32'(if16.ERR_CNT), 32'd3);

    clean(1, 1'b1);
    chk("clr/err", 32'(if16.ERR), 32'd0);
    chk("clr/cnt", 32'(if16.ERR_CNT), 32'd0);

    for (int i = 0; i < LOSS; i++) begin
      inject(2'b01, 1'b0, "loss");
      if (i == LOSS - 2) chk("loss/still_locked", 32'(if16.LOCKED), 32'd1);
    end
    chk("loss/unlocked", 32'(if16.LOCKED), 32'd0);
    chk("loss/cnt", 32'(if16.ERR_CNT), 32'd4);
    lock20("relock");

    clean(1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      inject($urandom_range(0, 1) != 0 ? 2'b01 : 2'b10, 1'b0, "sat");
      clean(1, 1'b0);
    end
    chk("sat/cnt4", 32'(if4.ERR_CNT), 32'd15);
    chk("sat/cnt16", 32'(if16.ERR_CNT), 32'd20);
    clean(5, 1'b0);
    chk("sat/hold4", 32'(if4.ERR_CNT), 32'd15);
    inject(2'b10, 1'b1, "clr_err");
    chk("clr_err/cnt4", 32'(if4.ERR_CNT), 32'd1);
    chk("clr_err/err4", 32'(if4.ERR), 32'd1);
    chk("clr_err/cnt16", 32'(if16.ERR_CNT), 32'd1);

    clean(1, 1'b1);
    for (int i = 0; i < 60; i++) begin
      gap = int'($urandom_range(0, 7));
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 2'($urandom), "gap");
      next_pair(p);
      cyc(1'b1, 1'b0, p, "gap_valid");
    end
    chk("gap/locked", 32'(if16.LOCKED), 32'd1);
    chk("gap/err", 32'(if16.ERR), 32'd0);

    inject(2'b01, 1'b0, "pre_reset");
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("async_rst/locked", 32'(if16.LOCKED), 32'd0);
    chk("async_rst/err", 32'(if16.ERR), 32'd0);
    chk("async_rst/cnt", 32'(if16.ERR_CNT), 32'd0);
    chk("async_rst/cnt4", 32'(if4.ERR_CNT), 32'd0);
    repeat (2) cyc(1'b1, 1'b0, 2'b11, "in_reset");
    rst_n = 1'b1;
    lock20("post_reset");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cyc(1'b0, $urandom_range(0, 29) == 0, 2'($urandom), "rnd_idle");
      end else begin
        next_pair(p);
        if ($urandom_range(0, 19) == 0) p = p ^ 2'($urandom_range(1, 3));
        cyc(1'b1, $urandom_range(0, 29) == 0, p, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prbs_ddr_checker.md
Name: prbs_ddr_checker

Overview:
- Receive-side companion to the DDR pattern generator in the IDDR/ODDR loopback testers.
- Consumes the 2-bit-per-cycle stream from an IDDR wrapper (Q1/Q2 pair) and self-synchronises a local PRBS-7 model (x^7+x^6+1) to that stream.
- Reports lock status, a sticky error flag and a saturating bit-error count.
- Drives a board LED/ERR line in hardware-loopback minitests.

Parameters:
- LOCK_CNT, 16: consecutive fully-matching valid cycles required in VERIFY before LOCKED asserts.
- LOSS_CNT, 4: consecutive mismatching valid cycles in LOCKED that force a return to HUNT.
- CNT_WIDTH, 16: width of ERR_CNT.
- SWAP, 0: 1 swaps D[0]/D[1] before use, for the OPPOSITE_EDGE bit order.

Ports:
- CLK      input   1          test clock; all logic on its rising edge
- RST_N    input   1          asynchronous, active-low reset
- D        input   2          received bit pair; D[0] is earlier in time, D[1] is later (after SWAP)
- VALID    input   1          D is valid this cycle; when low, all state holds
- ERR_CLR  input   1          synchronous clear of ERR and ERR_CNT
- LOCKED   output  1          checker aligned to the stream
- ERR      output  1          sticky: at least one bit error seen while LOCKED
- ERR_CNT  output  CNT_WIDTH  saturating count of bit errors while LOCKED

Behaviour:
- Reset (asynchronous, RST_N=0):
  - state=HUNT, LOCKED=0, ERR=0, ERR_CNT=0.
  - Seed register and the fill, match and bad counters are all cleared.
- All outputs are registered and update 1 cycle after the qualifying VALID cycle.
- PRBS rule: bit s[n] = s[n-7] XOR s[n-6]. The model advances 2 bits per valid cycle: D[0] first, then D[1].
- HUNT state:
  - Each valid cycle shifts D[0] and then D[1] into a 7-bit seed register.
  - After 4 valid cycles (8 bits), the last 7 bits become the model state.
  - If that seed is non-zero, go to VERIFY.
  - If the seed is all-zero (the PRBS lock-up state), restart the 4-cycle fill and stay in HUNT.
- VERIFY state:
  - Each valid cycle compares the 2 predicted bits with D.
  - Both bits match: increment match_cnt.
  - When match_cnt reaches LOCK_CNT: go to LOCKED and set LOCKED=1.
  - Any mismatch: go to HUNT, match_cnt=0. No error counting happens in VERIFY.
- LOCKED state:
  - The model runs freely and is never reseeded from D.
  - Per valid cycle, errors = popcount(predicted XOR D), a value of 0..2.
  - ERR_CNT += errors, saturating at 2^CNT_WIDTH-1. It never wraps.
  - ERR is set when errors > 0.
  - A cycle with errors > 0 increments bad_cnt. A cycle with 0 errors clears bad_cnt.
  - When bad_cnt reaches LOSS_CNT: go to HUNT, LOCKED=0. ERR and ERR_CNT are retained.
- ERR_CLR:
  - ERR_CLR=1 with no error that cycle: ERR=0 and ERR_CNT=0.
  - ERR_CLR=1 with a simultaneous error: the clear applies first, then that cycle's error. Result: ERR=1, ERR_CNT=errors.
  - ERR_CLR is independent of VALID and does not change state or LOCKED.
- VALID=0 cycles:
  - The model does not advance and no counter moves.
  - Gaps of any length are transparent.
- RST_N asserted mid-operation: immediate return to the reset values above. Re-lock needs the full HUNT + VERIFY sequence.
- Minimum lock latency from the first valid cycle: 4 + LOCK_CNT valid cycles, plus 1 register cycle.

Optional Feature:
- Macro: PRBS_CHK_FIRST_ERR_EN.
- With the macro defined:
  - A CNT_WIDTH-bit counter of valid cycles is kept. It resets to 0 when LOCKED rises and saturates.
  - Extra output FIRST_ERR_POS [CNT_WIDTH-1:0] captures that counter on the first error after lock or after ERR_CLR.
  - Extra output FIRST_ERR_VLD marks the capture. Both are cleared by ERR_CLR and by reset.
- Without the macro: neither the ports nor the counter exist, and the remaining behaviour is identical.

Test Plan:
- Clean PRBS-7 pair stream, VALID=1 from cycle 0 -> LOCKED=1 at cycle 21 (4+16+1). ERR=0 and ERR_CNT=0 after 1000 cycles.
- Locked, flip D[1] for one cycle -> ERR=1, ERR_CNT=1, LOCKED stays 1. Flip both bits for one cycle -> ERR_CNT=3.
- D held at 2'b00 for 200 cycles -> LOCKED never asserts and the FSM stays in HUNT (all-zero seed rejected).
- Locked, then 4 consecutive cycles with one bit wrong -> LOCKED=0 on the 5th cycle, ERR_CNT=4 retained. Clean stream resumes -> LOCKED=1 again after 21 cycles.
- CNT_WIDTH=4, inject 20 single-bit errors (kept below LOSS_CNT consecutive) -> ERR_CNT=15 and holds. ERR_CLR together with a 1-bit error -> ERR_CNT=1, ERR=1.
- Locked, VALID toggled 1-0-1 with gaps of up to 7 cycles and a clean stream -> no errors and LOCKED stays 1. RST_N pulsed low mid-stream -> all outputs 0 immediately, then re-lock after 21 valid cycles.
